// File: rtl/lcd_pkg.sv
// Shared types and address helper for the LCD framebuffer scheduler.
package lcd_pkg;

    localparam int LCD_ADDR_BITS = 30;

    typedef enum logic [1:0] {
        BUF_FREE,
        BUF_DRAWING,
        BUF_QUEUED,
        BUF_SCANOUT
    } lcd_buf_state_t;

    // base + idx*stride built from shifted copies of the stride; wraps mod 2^30.
    function automatic logic [LCD_ADDR_BITS-1:0] lcd_buf_addr(
        input logic [LCD_ADDR_BITS-1:0] base,
        input logic [LCD_ADDR_BITS-1:0] stride,
        input logic [1:0]               idx
    );
        logic [LCD_ADDR_BITS-1:0] off;
        off = '0;
        if (idx[0]) off = off + stride;
        if (idx[1]) off = off + {stride[LCD_ADDR_BITS-2:0], 1'b0};
        return base + off;
    endfunction

endpackage

// File: rtl/lcd_buf_picker.sv
// Lowest-index search over the buffer state array for one target state.
module lcd_buf_picker
    import lcd_pkg::*;
#(
    parameter int NUM_BUFFERS = 3,
    parameter int IDX_BITS    = 2
) (
    input  lcd_buf_state_t [NUM_BUFFERS-1:0] states,
    input  lcd_buf_state_t                   target,
    output logic                             found,
    output logic [IDX_BITS-1:0]              idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (states[i] == target) begin
                found = 1'b1;
                idx   = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/lcd_framebuffer_scheduler.sv
// Mailbox page-flip scheduler sharing 2..4 framebuffers between renderer and LCD scanout.
module lcd_framebuffer_scheduler
    import lcd_pkg::*;
#(
    parameter int NUM_BUFFERS = 3,
    parameter int IDX_BITS    = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                     CLK_PXCLK,
    input  logic                     RESET,
    input  logic                     FRAME_START,
    input  logic                     FRAME_END,
    input  logic [LCD_ADDR_BITS-1:0] BASE_ADDR,
    input  logic [LCD_ADDR_BITS-1:0] BUF_STRIDE,
    input  logic                     ACQ_REQ,
    output logic                     ACQ_ACK,
    output logic [IDX_BITS-1:0]      DRAW_IDX,
    output logic [LCD_ADDR_BITS-1:0] DRAW_ADDR,
    input  logic                     SUBMIT,
    output logic [LCD_ADDR_BITS-1:0] SCAN_ADDR,
    output logic                     FLIP_PENDING,
    output logic                     VBLANK_IRQ,
    output logic [CNT_BITS-1:0]      FRAME_COUNT,
    output logic [CNT_BITS-1:0]      DROP_COUNT
);

    lcd_buf_state_t [NUM_BUFFERS-1:0] buf_state;
    lcd_buf_state_t [NUM_BUFFERS-1:0] buf_state_nxt;

    logic                drawing;
    logic                free_found, queued_found, scan_found;
    logic [IDX_BITS-1:0] free_idx, queued_idx, scan_idx;
    logic                grant, submit_ok, flip, drop_evt;

    lcd_buf_picker #(.NUM_BUFFERS(NUM_BUFFERS), .IDX_BITS(IDX_BITS)) u_pick_free (
        .states(buf_state), .target(BUF_FREE),    .found(free_found),   .idx(free_idx)
    );
    lcd_buf_picker #(.NUM_BUFFERS(NUM_BUFFERS), .IDX_BITS(IDX_BITS)) u_pick_queued (
        .states(buf_state), .target(BUF_QUEUED),  .found(queued_found), .idx(queued_idx)
    );
    lcd_buf_picker #(.NUM_BUFFERS(NUM_BUFFERS), .IDX_BITS(IDX_BITS)) u_pick_scan (
        .states(buf_state), .target(BUF_SCANOUT), .found(scan_found),   .idx(scan_idx)
    );

    // All decisions use the registered states, so a buffer freed by a flip waits a cycle.
    assign grant        = ACQ_REQ && !drawing && !ACQ_ACK && free_found;
    assign submit_ok    = SUBMIT && drawing;
    assign flip         = FRAME_START && queued_found;
    assign drop_evt     = submit_ok && queued_found && !FRAME_START;
    assign FLIP_PENDING = queued_found;

    always_comb begin
        buf_state_nxt = buf_state;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (flip && IDX_BITS'(i) == queued_idx) buf_state_nxt[i] = BUF_SCANOUT;
            if (flip && IDX_BITS'(i) == scan_idx)   buf_state_nxt[i] = BUF_FREE;
            if (drop_evt && IDX_BITS'(i) == queued_idx) buf_state_nxt[i] = BUF_FREE;
            if (submit_ok && IDX_BITS'(i) == DRAW_IDX)  buf_state_nxt[i] = BUF_QUEUED;
            if (grant && IDX_BITS'(i) == free_idx)      buf_state_nxt[i] = BUF_DRAWING;
        end
    end

    always_ff @(posedge CLK_PXCLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_BUFFERS; i++)
                buf_state[i] <= (i == 0) ? BUF_SCANOUT : BUF_FREE;
            drawing     <= 1'b0;
            ACQ_ACK     <= 1'b0;
            DRAW_IDX    <= '0;
            DRAW_ADDR   <= BASE_ADDR;
            SCAN_ADDR   <= BASE_ADDR;
            VBLANK_IRQ  <= 1'b0;
            FRAME_COUNT <= '0;
            DROP_COUNT  <= '0;
        end else begin
            buf_state  <= buf_state_nxt;
            ACQ_ACK    <= grant;
            VBLANK_IRQ <= FRAME_END;
            if (FRAME_START)
                FRAME_COUNT <= FRAME_COUNT + CNT_BITS'(1);
            if (flip)
                SCAN_ADDR <= lcd_buf_addr(BASE_ADDR, BUF_STRIDE, queued_idx);
            if (submit_ok)
                drawing <= 1'b0;
            if (grant) begin
                drawing   <= 1'b1;
                DRAW_IDX  <= free_idx;
                DRAW_ADDR <= lcd_buf_addr(BASE_ADDR, BUF_STRIDE, free_idx);
            end
            if (drop_evt && DROP_COUNT != '1)
                DROP_COUNT <= DROP_COUNT + CNT_BITS'(1);
        end
    end

`ifndef SYNTHESIS
    function automatic int count_state(lcd_buf_state_t s);
        int n;
        n = 0;
        for (int i = 0; i < NUM_BUFFERS; i++)
            if (buf_state[i] == s) n++;
        return n;
    endfunction

    always @(posedge CLK_PXCLK) begin
        if (!RESET) begin
            assert (scan_found && count_state(BUF_SCANOUT) == 1);
            assert (count_state(BUF_QUEUED) <= 1);
            assert (count_state(BUF_DRAWING) == (drawing ? 1 : 0));
        end
    end
`endif

endmodule

// File: tb/tb_lcd_framebuffer_scheduler.sv
// Table-driven, directed and randomized checks of lcd_framebuffer_scheduler against a buffer-role model.
module tb_lcd_framebuffer_scheduler;

    localparam int NB = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, fs, fe, req, sub;
    logic [29:0] base, stride;
    logic        ack, pend, vbl;
    logic [1:0]  didx;
    logic [29:0] daddr, saddr;
    logic [15:0] fcnt, dcnt;

    logic        rst2, fs2, fe2, req2, sub2;
    logic        ack2, pend2, vbl2;
    logic [1:0]  didx2;
    logic [29:0] daddr2, saddr2;
    logic [15:0] fcnt2, dcnt2;

    int errors = 0;
    int checks = 0;

    lcd_framebuffer_scheduler #(.NUM_BUFFERS(NB)) dut (
        .CLK_PXCLK(clk), .RESET(rst), .FRAME_START(fs), .FRAME_END(fe),
        .BASE_ADDR(base), .BUF_STRIDE(stride), .ACQ_REQ(req), .ACQ_ACK(ack),
        .DRAW_IDX(didx), .DRAW_ADDR(daddr), .SUBMIT(sub), .SCAN_ADDR(saddr),
        .FLIP_PENDING(pend), .VBLANK_IRQ(vbl), .FRAME_COUNT(fcnt), .DROP_COUNT(dcnt)
    );

    lcd_framebuffer_scheduler #(.NUM_BUFFERS(2)) dut2 (
        .CLK_PXCLK(clk), .RESET(rst2), .FRAME_START(fs2), .FRAME_END(fe2),
        .BASE_ADDR(base), .BUF_STRIDE(stride), .ACQ_REQ(req2), .ACQ_ACK(ack2),
        .DRAW_IDX(didx2), .DRAW_ADDR(daddr2), .SUBMIT(sub2), .SCAN_ADDR(saddr2),
        .FLIP_PENDING(pend2), .VBLANK_IRQ(vbl2), .FRAME_COUNT(fcnt2), .DROP_COUNT(dcnt2)
    );

    // Model tracks which buffer holds each role (-1 = none); everything else is free.
    int          m_scan, m_q, m_d, m_didx, m_frame, m_drop;
    bit          m_ack, m_vbl;
    logic [29:0] m_daddr, m_saddr;

    function automatic logic [29:0] addr_of(int i);
        longint a;
        a = longint'(base) + longint'(i) * longint'(stride);
        return a[29:0];
    endfunction

    function automatic void model_step(bit r, bit f, bit e, bit q, bit s);
        int  nfree, old_q;
        bit  g;
        if (r) begin
            m_scan = 0; m_q = -1; m_d = -1; m_ack = 0; m_vbl = 0;
            m_didx = 0; m_daddr = base; m_saddr = base; m_frame = 0; m_drop = 0;
            return;
        end
        nfree = -1;
        for (int i = NB - 1; i >= 0; i--)
            if (i != m_scan && i != m_q && i != m_d) nfree = i;
        g = q && (m_d < 0) && !m_ack && (nfree >= 0);
        old_q = m_q;
        if (f && m_q >= 0) begin
            m_scan  = m_q;
            m_q     = -1;
            m_saddr = addr_of(m_scan);
        end
        if (s && m_d >= 0) begin
            if (old_q >= 0 && !f && m_drop < 65535) m_drop++;
            m_q = m_d;
            m_d = -1;
        end
        if (g) begin
            m_d = nfree; m_didx = nfree; m_daddr = addr_of(nfree);
        end
        m_ack   = g;
        m_vbl   = e;
        if (f) m_frame = (m_frame + 1) % 65536;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(bit r, bit f, bit e, bit q, bit s);
        rst = r; fs = f; fe = e; req = q; sub = s;
        @(posedge clk); #1;
        model_step(r, f, e, q, s);
        chk("ack",          32'(ack),   32'(m_ack));
        chk("draw_idx",     32'(didx),  32'(m_didx));
        chk("draw_addr",    32'(daddr), 32'(m_daddr));
        chk("scan_addr",    32'(saddr), 32'(m_saddr));
        chk("flip_pending", 32'(pend),  32'(m_q >= 0));
        chk("vblank",       32'(vbl),   32'(m_vbl));
        chk("frame_count",  32'(fcnt),  32'(m_frame));
        chk("drop_count",   32'(dcnt),  32'(m_drop));
    endtask

    task automatic cyc2(bit r, bit f, bit q, bit s);
        rst2 = r; fs2 = f; req2 = q; sub2 = s;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          r, f, e, q, s;
        bit          e_ack;
        bit [1:0]    e_didx;
        logic [29:0] e_scan;
        bit          e_pend;
        int          e_frame, e_drop;
        bit          e_vbl;
    } vec_t;

    vec_t vt[21];

    initial begin
        //          r f e q s  ack didx scan       pend frame drop vbl
        vt[0]  = '{1,0,0,0,0, 0, 2'd0, 30'h00100,   0, 0, 0, 0};
        vt[1]  = '{0,0,0,1,0, 1, 2'd1, 30'h00100,   0, 0, 0, 0};
        vt[2]  = '{0,0,0,1,0, 0, 2'd1, 30'h00100,   0, 0, 0, 0};
        vt[3]  = '{0,0,0,0,1, 0, 2'd1, 30'h00100,   1, 0, 0, 0};
        vt[4]  = '{0,1,0,0,0, 0, 2'd1, 30'h2EF00,   0, 1, 0, 0};
        vt[5]  = '{0,0,0,1,0, 1, 2'd0, 30'h2EF00,   0, 1, 0, 0};
        vt[6]  = '{0,0,0,0,1, 0, 2'd0, 30'h2EF00,   1, 1, 0, 0};
        vt[7]  = '{0,0,0,1,0, 1, 2'd2, 30'h2EF00,   1, 1, 0, 0};
        vt[8]  = '{0,0,0,0,1, 0, 2'd2, 30'h2EF00,   1, 1, 1, 0};
        vt[9]  = '{0,1,0,0,0, 0, 2'd2, 30'h5DD00,   0, 2, 1, 0};
        vt[10] = '{0,0,0,1,0, 1, 2'd0, 30'h5DD00,   0, 2, 1, 0};
        vt[11] = '{0,0,0,0,1, 0, 2'd0, 30'h5DD00,   1, 2, 1, 0};
        vt[12] = '{0,0,0,1,0, 1, 2'd1, 30'h5DD00,   1, 2, 1, 0};
        vt[13] = '{0,1,0,0,1, 0, 2'd1, 30'h00100,   1, 3, 1, 0};
        vt[14] = '{0,1,0,0,0, 0, 2'd1, 30'h2EF00,   0, 4, 1, 0};
        vt[15] = '{0,0,0,1,0, 1, 2'd0, 30'h2EF00,   0, 4, 1, 0};
        vt[16] = '{0,0,0,0,1, 0, 2'd0, 30'h2EF00,   1, 4, 1, 0};
        vt[17] = '{0,0,0,1,0, 1, 2'd2, 30'h2EF00,   1, 4, 1, 0};
        vt[18] = '{1,0,0,1,0, 0, 2'd0, 30'h00100,   0, 0, 0, 0};
        vt[19] = '{0,0,1,0,0, 0, 2'd0, 30'h00100,   0, 0, 0, 1};
        vt[20] = '{0,0,0,0,0, 0, 2'd0, 30'h00100,   0, 0, 0, 0};

        rst = 1; fs = 0; fe = 0; req = 0; sub = 0;
        rst2 = 1; fs2 = 0; fe2 = 0; req2 = 0; sub2 = 0;
        base = 30'h100; stride = 30'h2EE00;

        // Two buffers: with one scanning and one queued, a held request waits for the flip.
        cyc2(1, 0, 0, 0);
        cyc2(0, 0, 1, 0);
        chk("nb2 first ack", 32'(ack2), 32'd1);
        chk("nb2 first idx", 32'(didx2), 32'd1);
        cyc2(0, 0, 1, 1);
        chk("nb2 pending", 32'(pend2), 32'd1);
        chk("nb2 no ack while drawing", 32'(ack2), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc2(0, 0, 1, 0);
            chk($sformatf("nb2 no free ack %0d", k), 32'(ack2), 32'd0);
        end
        cyc2(0, 1, 1, 0);
        chk("nb2 no ack at flip edge", 32'(ack2), 32'd0);
        chk("nb2 scan after flip", 32'(saddr2), 32'h2EF00);
        cyc2(0, 0, 1, 0);
        chk("nb2 ack after flip", 32'(ack2), 32'd1);
        chk("nb2 idx after flip", 32'(didx2), 32'd0);
        chk("nb2 addr after flip", 32'(daddr2), 32'h100);
        cyc2(0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            cyc(vt[i].r, vt[i].f, vt[i].e, vt[i].q, vt[i].s);
            chk($sformatf("row%0d ack", i),   32'(ack),   32'(vt[i].e_ack));
            chk($sformatf("row%0d idx", i),   32'(didx),  32'(vt[i].e_didx));
            chk($sformatf("row%0d scan", i),  32'(saddr), 32'(vt[i].e_scan));
            chk($sformatf("row%0d pend", i),  32'(pend),  32'(vt[i].e_pend));
            chk($sformatf("row%0d frame", i), 32'(fcnt),  32'(vt[i].e_frame));
            chk($sformatf("row%0d drop", i),  32'(dcnt),  32'(vt[i].e_drop));
            chk($sformatf("row%0d vbl", i),   32'(vbl),   32'(vt[i].e_vbl));
        end

        // Random traffic with a wrapping stride.
        base   = 30'($urandom);
        stride = 30'($urandom);
        cyc(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
